// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the memory access unit: RISC-V load/store
//   opcodes, func3 access-size encodings and the control FSM state type.
package mem_access_unit_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;

    // func3[1:0] access size; func3[2] selects zero-extension on loads
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int unsigned F3_UNSIGNED_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mem_access_unit_store_aligner.sv
// store_aligner
//   Combinational byte-lane mapper for one memory-stage access.
//   Ports:
//     i_size        access size, func3[1:0]
//     i_addr_lo     byte offset within the word, addr[1:0]
//     i_wdata       store source data, byte 0 in [7:0]
//     o_we          byte write enables for a store at this offset
//     o_wdata       source byte/half replicated into every lane
//     o_misaligned  half not on a 2-byte boundary or word not on a 4-byte one
import mem_access_unit_pkg::*;

module store_aligner (
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata,
    output logic        o_misaligned
);

    always_comb begin
        o_we         = '0;
        o_wdata      = '0;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_we    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_we         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            // Word, and the unused 2'b11 encoding, are handled as full words
            default: begin
                o_we         = 4'b1111;
                o_wdata      = i_wdata;
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage controller: accepts one load/store at a time from the
//   pipeline, issues a single word-aligned memory request, waits (bounded by
//   TIMEOUT_CYCLES) for a load response and reports completion with a
//   one-cycle done pulse carrying the raw word and the captured op.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     op_valid/op_ready     operation handshake (ready only in IDLE)
//     op_inst/addr/wdata    instruction, byte address, store data
//     mem_req_*             memory request (valid held until ready)
//     mem_resp_valid/rdata  load response, honoured only in RESP
//     done_*                completion pulse, raw read word, captured op,
//                           misaligned/timeout error flags
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] op_inst,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    output logic        done_valid,
    output logic [31:0] done_rdata,
    output logic [31:0] done_inst,
    output logic [31:0] done_addr,
    output logic        done_misaligned,
    output logic        done_timeout
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_inst;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_we;
    logic        r_mis;
    logic        r_to;
    logic [15:0] r_cnt;

    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_r_is_store;
    logic        w_expired;
    logic [3:0]  w_we;
    logic [31:0] w_lane;
    logic        w_mis;

    store_aligner u_aligner (
        .i_size       (op_inst[13:12]),
        .i_addr_lo    (op_addr[1:0]),
        .i_wdata      (op_wdata),
        .o_we         (w_we),
        .o_wdata      (w_lane),
        .o_misaligned (w_mis)
    );

    assign w_is_load    = (op_inst[6:0] == OPC_LOAD);
    assign w_is_store   = (op_inst[6:0] == OPC_STORE);
    assign w_is_mem     = w_is_load || w_is_store;
    assign w_accept     = op_valid && op_ready;
    assign w_r_is_store = (r_inst[6:0] == OPC_STORE);
    assign w_expired    = (r_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and control outputs; rst_n gates op_ready so the unit
    // never advertises readiness while reset is held.
    always_comb begin
        w_next          = r_state;
        op_ready        = 1'b0;
        mem_req_valid   = 1'b0;
        done_valid      = 1'b0;
        done_misaligned = 1'b0;
        done_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = rst_n;
                if (w_accept) begin
                    w_next = (w_is_mem && !w_mis) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next = w_r_is_store ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                // A response on the expiry cycle takes priority over timeout
                if (mem_resp_valid || w_expired) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_valid      = 1'b1;
                done_misaligned = r_mis;
                done_timeout    = r_to;
                w_next          = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operation capture, timeout counter and read-data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_we    <= '0;
            r_mis   <= 1'b0;
            r_to    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_inst  <= op_inst;
                        r_addr  <= op_addr;
                        r_wdata <= w_is_store ? w_lane : '0;
                        r_we    <= (w_is_store && !w_mis) ? w_we : '0;
                        r_rdata <= '0;
                        r_mis   <= w_is_mem && w_mis;
                        r_to    <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready && !w_r_is_store) begin
                        r_cnt <= '0;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        r_rdata <= mem_resp_rdata;
                    end else if (w_expired) begin
                        r_to <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_addr  = {r_addr[31:2], 2'b00};
    assign mem_req_we    = r_we;
    assign mem_req_wdata = r_wdata;
    assign done_rdata    = r_rdata;
    assign done_inst     = r_inst;
    assign done_addr     = r_addr;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_inst;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_we;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic [31:0] done_inst;
    logic [31:0] done_addr;
    logic        done_misaligned;
    logic        done_timeout;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    localparam logic [31:0] I_SB  = 32'h0000_0023;
    localparam logic [31:0] I_SH  = 32'h0000_1023;
    localparam logic [31:0] I_SW  = 32'h0000_2023;
    localparam logic [31:0] I_LH  = 32'h0000_1003;
    localparam logic [31:0] I_LW  = 32'h0000_2003;
    localparam logic [31:0] I_ADD = 32'h0000_0013;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .op_inst         (op_inst),
        .op_addr         (op_addr),
        .op_wdata        (op_wdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_req_we      (mem_req_we),
        .mem_req_wdata   (mem_req_wdata),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_rdata  (mem_resp_rdata),
        .done_valid      (done_valid),
        .done_rdata      (done_rdata),
        .done_inst       (done_inst),
        .done_addr       (done_addr),
        .done_misaligned (done_misaligned),
        .done_timeout    (done_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Presents an op for the current cycle; caller steps and drops op_valid
    task automatic present(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wd);
        op_valid = 1'b1;
        op_inst  = inst;
        op_addr  = addr;
        op_wdata = wd;
    endtask

    initial begin
        rst_n          = 1'b0;
        op_valid       = 1'b0;
        op_inst        = '0;
        op_addr        = '0;
        op_wdata       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;

        // Reset state
        step(); step();
        chk("rst op_ready", {31'b0, op_ready}, 32'd0);
        chk("rst req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst done_valid", {31'b0, done_valid}, 32'd0);
        chk("rst req_we", {28'b0, mem_req_we}, 32'd0);
        chk("rst done_rdata", done_rdata, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post-rst op_ready", {31'b0, op_ready}, 32'd1);

        // SB to 0x103, ready immediate: done at cycle 2
        mem_req_ready = 1'b1;
        present(I_SB, 32'h0000_0103, 32'h0000_00AB);
        chk("sb c0 op_ready", {31'b0, op_ready}, 32'd1);
        step(); op_valid = 1'b0;
        chk("sb c1 req_valid", {31'b0, mem_req_valid}, 32'd1);
        chk("sb c1 addr", mem_req_addr, 32'h0000_0100);
        chk("sb c1 we", {28'b0, mem_req_we}, 32'h8);
        chk("sb c1 wdata", mem_req_wdata, 32'hABAB_ABAB);
        chk("sb c1 op_ready", {31'b0, op_ready}, 32'd0);
        step();
        chk("sb c2 done_valid", {31'b0, done_valid}, 32'd1);
        chk("sb c2 req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("sb c2 flags", {30'b0, done_misaligned, done_timeout}, 32'd0);
        step();
        chk("sb c3 done_valid", {31'b0, done_valid}, 32'd0);
        chk("sb c3 op_ready", {31'b0, op_ready}, 32'd1);

        // SH to 0x102: upper half lanes
        present(I_SH, 32'h0000_0102, 32'h5555_1234);
        step(); op_valid = 1'b0;
        chk("sh we", {28'b0, mem_req_we}, 32'hC);
        chk("sh wdata", mem_req_wdata, 32'h1234_1234);
        step();
        chk("sh done_valid", {31'b0, done_valid}, 32'd1);
        step();

        // SW to 0x204
        present(I_SW, 32'h0000_0204, 32'h1122_3344);
        step(); op_valid = 1'b0;
        chk("sw we", {28'b0, mem_req_we}, 32'hF);
        chk("sw wdata", mem_req_wdata, 32'h1122_3344);
        chk("sw addr", mem_req_addr, 32'h0000_0204);
        step(); step();

        // LW from 0x200, ready delayed to cycle 4, response at cycle 6
        mem_req_ready = 1'b0;
        present(I_LW, 32'h0000_0200, 32'hFFFF_FFFF);
        step(); op_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("lw hold valid", {31'b0, mem_req_valid}, 32'd1);
            chk("lw hold addr", mem_req_addr, 32'h0000_0200);
            chk("lw hold we", {28'b0, mem_req_we}, 32'h0);
            // a response while in REQ must be ignored
            mem_resp_valid = (c == 2);
            mem_resp_rdata = 32'h0BAD_0BAD;
            step();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b1;
        chk("lw c4 valid", {31'b0, mem_req_valid}, 32'd1);
        step(); mem_req_ready = 1'b0;
        chk("lw c5 valid dropped", {31'b0, mem_req_valid}, 32'd0);
        chk("lw c5 done_valid", {31'b0, done_valid}, 32'd0);
        step();
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
        step(); mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        chk("lw done_valid", {31'b0, done_valid}, 32'd1);
        chk("lw done_rdata", done_rdata, 32'hDEAD_BEEF);
        chk("lw done_addr", done_addr, 32'h0000_0200);
        chk("lw done_inst", done_inst, I_LW);
        chk("lw done_timeout", {31'b0, done_timeout}, 32'd0);
        step();
        chk("lw single pulse", {31'b0, done_valid}, 32'd0);

        // LH to 0x201: misaligned, done at cycle 1, no request
        present(I_LH, 32'h0000_0201, 32'h0);
        step(); op_valid = 1'b0;
        chk("lh done_valid", {31'b0, done_valid}, 32'd1);
        chk("lh misaligned", {31'b0, done_misaligned}, 32'd1);
        chk("lh req_valid", {31'b0, mem_req_valid}, 32'd0);
        step();

        // Non-memory op: straight to DONE, rdata 0, no error flags
        present(I_ADD, 32'h0000_0203, 32'h0);
        step(); op_valid = 1'b0;
        chk("alu done_valid", {31'b0, done_valid}, 32'd1);
        chk("alu flags", {30'b0, done_misaligned, done_timeout}, 32'd0);
        chk("alu rdata", done_rdata, 32'd0);
        chk("alu req_valid", {31'b0, mem_req_valid}, 32'd0);
        step();

        // LW immediate: req at 1, resp at 2, done at 3
        mem_req_ready = 1'b1;
        present(I_LW, 32'h0000_0300, 32'h0);
        step(); op_valid = 1'b0;
        chk("lwi c1 req_valid", {31'b0, mem_req_valid}, 32'd1);
        step();
        chk("lwi c2 done_valid", {31'b0, done_valid}, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
        step(); mem_resp_valid = 1'b0;
        chk("lwi c3 done_valid", {31'b0, done_valid}, 32'd1);
        chk("lwi c3 rdata", done_rdata, 32'hCAFE_F00D);
        step();

        // Timeout: RESP cycles 2..5 without response, done at 6
        present(I_LW, 32'h0000_0400, 32'h0);
        step(); op_valid = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("to waiting", {31'b0, done_valid}, 32'd0);
        end
        step();
        chk("to done_valid", {31'b0, done_valid}, 32'd1);
        chk("to done_timeout", {31'b0, done_timeout}, 32'd1);
        chk("to done_rdata", done_rdata, 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1357_9BDF;
        step(); mem_resp_valid = 1'b0;
        chk("to late resp ignored", {31'b0, done_valid}, 32'd0);
        chk("to late op_ready", {31'b0, op_ready}, 32'd1);

        // Response on the expiry cycle (RESP cycle 5) wins over timeout
        present(I_LW, 32'h0000_0500, 32'h0);
        step(); op_valid = 1'b0;
        step(); step(); step(); step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h2468_ACE0;
        step(); mem_resp_valid = 1'b0;
        chk("exp done_valid", {31'b0, done_valid}, 32'd1);
        chk("exp no timeout", {31'b0, done_timeout}, 32'd0);
        chk("exp rdata", done_rdata, 32'h2468_ACE0);
        step();

        // Reset pulsed while in RESP
        present(I_LW, 32'h0000_0604, 32'h0);
        step(); op_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst req_addr", mem_req_addr, 32'd0);
        chk("arst done_addr", done_addr, 32'd0);
        chk("arst op_ready", {31'b0, op_ready}, 32'd0);
        chk("arst done_valid", {31'b0, done_valid}, 32'd0);
        step();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_0000;
        step();
        rst_n = 1'b1;
        step(); mem_resp_valid = 1'b0;
        chk("arst rel op_ready", {31'b0, op_ready}, 32'd1);
        chk("arst rel done_valid", {31'b0, done_valid}, 32'd0);
        chk("arst rel rdata", done_rdata, 32'd0);
        step();
        chk("arst idle done_valid", {31'b0, done_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 255: maximum cycles spent in RESP waiting for a load response before abort (range 1..65535).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 op_valid  input  1  pipeline presents a memory-stage operation.
REQ-005 op_ready  output  1  unit accepts operation (high only in IDLE with rst_n high).
REQ-006 op_inst  input  32  instruction; opcode inst[6:0], func3 inst[14:12].
REQ-007 op_addr  input  32  effective byte address.
REQ-008 op_wdata  input  32  store source data, byte 0 in [7:0].
REQ-009 mem_req_valid  output  1  memory request valid.
REQ-010 mem_req_ready  input  1  memory accepts request.
REQ-011 mem_req_addr  output  32  word-aligned address, {op_addr[31:2],2'b00}.
REQ-012 mem_req_we  output  4  byte write enables; 4'b0000 for loads.
REQ-013 mem_req_wdata  output  32  lane-shifted store data.
REQ-014 mem_resp_valid  input  1  load response valid.
REQ-015 mem_resp_rdata  input  32  raw word read.
REQ-016 done_valid  output  1  one-cycle completion pulse.
REQ-017 done_rdata  output  32  registered raw word, unextended, consumed by the load extender.
REQ-018 done_inst / done_addr  output  32 each  captured op_inst / op_addr for the extender.
REQ-019 done_misaligned / done_timeout  output  1 each  error flags, valid only with done_valid.

Function
REQ-020 States are IDLE, REQ, RESP, DONE; an op is accepted on op_valid&&op_ready, and inst, addr, and wdata are captured.
REQ-021 Load means opcode 7'h03, store means 7'h23; any other opcode goes IDLE->DONE, with no memory request and done_rdata=0.
REQ-022 Misalignment means halfword (func3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]!=0; the op goes IDLE->DONE with no request and done_misaligned=1.
REQ-023 Store enables: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111; wdata byte/half replicated into all lanes.
REQ-024 In REQ, mem_req_valid=1 with addr/we/wdata held stable until mem_req_ready; valid SHALL NOT drop before the handshake.
REQ-025 Store handshake goes REQ->DONE; load handshake goes REQ->RESP and clears the timeout counter.
REQ-026 In RESP, mem_resp_valid captures mem_resp_rdata into done_rdata and goes to DONE; mem_resp_valid in IDLE, REQ, or DONE is ignored.
REQ-027 Timeout: after TIMEOUT_CYCLES RESP cycles with no response, go to DONE with done_timeout=1 and done_rdata=0; a response arriving on the expiry cycle wins (no timeout).
REQ-028 DONE lasts exactly one cycle with done_valid=1, then returns to IDLE; op_ready is 0 in REQ, RESP, and DONE.
REQ-029 Latency: with ready and response both immediate, accept at cycle 0, mem_req_valid at cycle 1, mem_resp_valid at cycle 2, done_valid at cycle 3; a store with immediate ready gives done_valid at cycle 2.
REQ-030 At most one operation is outstanding; back-to-back ops sustain one op per 3 cycles (store) or 4 cycles (load) minimum.

Reset
REQ-031 While rst_n=0: state=IDLE; timeout counter=0; op_ready, mem_req_valid, and done_valid=0; all data outputs=0; mem_req_we=0.
REQ-032 Reset asserted mid-operation abandons the op with no done_valid; a late mem_resp_valid after reset is ignored.
REQ-033 op_ready rises in the first cycle after rst_n deasserts.

Structure
REQ-034 Shared package holds OPC_LOAD=7'h03 and OPC_STORE=7'h23, the func3 size encodings (00 byte, 01 half, 10 word, bit2 unsigned), and the state enum.
REQ-035 One combinational sub-module, store_aligner, maps (func3, addr[1:0], wdata) to (we, lane data, misaligned).

Verification
REQ-036 SB to addr 0x103 with wdata 0x000000AB, ready immediate -> mem_req_addr=0x100, we=4'b1000, wdata=0xABABABAB, done_valid at cycle 2.
REQ-037 LW from 0x200, ready delayed 3 cycles, response 0xDEADBEEF 2 cycles later -> request held stable, done_rdata=0xDEADBEEF, done_addr=0x200, single pulse.
REQ-038 LH to 0x201 -> no mem_req_valid, done_valid with done_misaligned=1 at cycle 1.
REQ-039 LW with TIMEOUT_CYCLES=4 and no response -> done_timeout=1, done_rdata=0 after 4 RESP cycles; a response 1 cycle later is ignored.
REQ-040 rst_n pulsed low while in RESP -> outputs 0 immediately (asynchronously), no done_valid, op_ready=1 the cycle after release.
